// File: rtl/fifo_arbiter_pkg.sv
// Shared constants for the two-requester bit FIFO: default depth, count-width
// derivation and requester indices.
package fifo_arbiter_pkg;

    localparam int DEPTH_DEFAULT = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Width needed to represent occupancies 0..depth inclusive.
    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_arbiter_bit_queue.sv
// Shift-register storage for the arbiter FIFO: entry 0 is the head, a pop shifts
// everything one place toward it, a push writes a single indexed slot.
module bit_queue
    import fifo_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = cw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          pop,
    input  logic          push,
    input  logic [CW-1:0] wr_idx,
    input  logic          wr_bit,
    output logic          head
);

    logic [DEPTH-1:0] mem;
    logic [DEPTH-1:0] mem_next;

    // The write index is already the post-shift tail, so shift first, then write.
    always_comb begin
        // NOTE: default assigned first so every path drives mem_next and no latch is inferred.
        mem_next = mem;
        if (pop)
            mem_next = mem >> 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_idx == i[CW-1:0]))
                mem_next[i] = wr_bit;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the storage is cleared on reset and flush, because stale bits must never reappear at the head.
        if (reset || clear)
            mem <= '0;
        else
            // NOTE: non-blocking so every register samples pre-edge values together.
            mem <= mem_next;
    end

    assign head = mem[0];

endmodule

// File: rtl/fifo_arbiter.sv
// Two requesters push single bits into a shared FIFO under round-robin arbitration;
// one consumer pops with one-edge latency. Flush empties the queue; errors pulse.
module fifo_arbiter
    import fifo_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = cw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          d0,
    input  logic          req1,
    input  logic          d1,
    output logic          grant0,
    output logic          grant1,
    input  logic          pop_req,
    input  logic          flush,
    output logic          dout,
    output logic          pop_valid,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow_err,
    output logic          underflow_err
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic          last_grant;
    logic          head;
    logic          pop_ok;
    logic          slot_ok;
    logic          push_ok;
    logic          wr_bit;
    logic [CW-1:0] wr_idx;
    logic [CW-1:0] count_next;
    logic          ovf_next;
    logic          unf_next;

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        pop_ok     = pop_req && !flush && !reset && (count != '0);
        // A pop at the same edge frees a slot even when the queue is full.
        slot_ok    = !flush && !reset && ((count != FULL_CNT) || pop_ok);

        if (slot_ok) begin
            if (req0 && req1) begin
                grant0 = (last_grant == REQ1);
                grant1 = (last_grant == REQ0);
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end

        push_ok    = grant0 || grant1;
        wr_bit     = grant0 ? d0 : d1;
        wr_idx     = pop_ok ? CW'(count - 1'b1) : count;

        ovf_next   = (req0 || req1) && !slot_ok && !flush;
        unf_next   = pop_req && (count == '0) && !flush;

        count_next = count;
        if (flush)
            count_next = '0;
        else if (push_ok && !pop_ok)
            count_next = CW'(count + 1'b1);
        else if (pop_ok && !push_ok)
            count_next = CW'(count - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            last_grant    <= REQ1;
            dout          <= 1'b0;
            pop_valid     <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            count         <= count_next;
            pop_valid     <= pop_ok;
            overflow_err  <= ovf_next;
            underflow_err <= unf_next;
            if (pop_ok)
                dout <= head;
            if (push_ok)
                last_grant <= grant1 ? REQ1 : REQ0;
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    bit_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk    (clk),
        .reset  (reset),
        .clear  (flush),
        .pop    (pop_ok),
        .push   (push_ok),
        .wr_idx (wr_idx),
        .wr_bit (wr_bit),
        .head   (head)
    );

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: fill/overflow, round-robin, pop+push at full,
// underflow, flush priority and mid-stream reset, with hand-computed expectations.
module tb_fifo_arbiter;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset, req0, d0, req1, d1, pop_req, flush;
    logic          grant0, grant1, dout, pop_valid, full, empty;
    logic          overflow_err, underflow_err;
    logic [CW-1:0] count;

    int tests = 0;
    int fails = 0;

    fifo_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req0          (req0),
        .d0            (d0),
        .req1          (req1),
        .d1            (d1),
        .grant0        (grant0),
        .grant1        (grant1),
        .pop_req       (pop_req),
        .flush         (flush),
        .dout          (dout),
        .pop_valid     (pop_valid),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 0; req1 = 0; d0 = 0; d1 = 0; pop_req = 0; flush = 0;
    endtask

    logic [3:0] fill_bits;
    logic [3:0] drain_bits;

    initial begin
        reset = 1; idle();
        req0  = 1;
        #1;
        check("grant0_in_reset", grant0, 0);
        tick();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_dout", dout, 0);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_ovf", overflow_err, 0);
        check("rst_unf", underflow_err, 0);
        reset = 0; idle();

        // Fill with 1,0,1,1 from requester 0.
        fill_bits = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            req0 = 1; d0 = fill_bits[i];
            #1;
            check("fill_grant0", grant0, 1);
            tick();
            check("fill_count", count, i + 1);
        end
        check("fill_full", full, 1);
        req0 = 1; d0 = 0;
        #1;
        check("ovf_grant0", grant0, 0);
        tick();
        check("ovf_pulse", overflow_err, 1);
        check("ovf_count", count, 4);
        idle();
        tick();
        check("ovf_drop", overflow_err, 0);

        // Full: pop plus push from requester 1 in the same edge.
        pop_req = 1; req1 = 1; d1 = 0;
        #1;
        check("pp_grant1", grant1, 1);
        tick();
        check("pp_count", count, 4);
        check("pp_dout", dout, 1);
        check("pp_valid", pop_valid, 1);
        check("pp_ovf", overflow_err, 0);
        // Queue is now 0,1,1,0 head first.
        idle();
        drain_bits = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            pop_req = 1;
            tick();
            check("drain_dout", dout, drain_bits[i]);
            check("drain_valid", pop_valid, 1);
        end
        check("drain_empty", empty, 1);
        idle();
        tick();
        check("idle_valid", pop_valid, 0);

        // Both request; last_grant is 1 so requester 0 leads.
        for (int i = 0; i < 4; i++) begin
            req0 = 1; d0 = 1; req1 = 1; d1 = 0;
            #1;
            check("rr_grant0", grant0, (i % 2) == 0);
            check("rr_grant1", grant1, (i % 2) == 1);
            tick();
        end
        check("rr_count", count, 4);
        idle();
        pop_req = 1;
        tick();
        check("rr_pop0", dout, 1);
        check("rr_count3", count, 3);

        // Flush outranks pop and push.
        flush = 1; pop_req = 1; req0 = 1; d0 = 1;
        #1;
        check("fl_grant0", grant0, 0);
        check("fl_grant1", grant1, 0);
        tick();
        check("fl_count", count, 0);
        check("fl_valid", pop_valid, 0);
        check("fl_ovf", overflow_err, 0);
        check("fl_unf", underflow_err, 0);
        check("fl_dout_hold", dout, 1);
        idle();

        // Flushed entries must be zero: pop what a later push leaves behind.
        req1 = 1; d1 = 0;
        tick();
        idle();
        pop_req = 1;
        tick();
        check("fl_zero_dout", dout, 0);
        check("fl_zero_valid", pop_valid, 1);
        idle();

        // Underflow keeps dout: push a 1, pop it, pop again empty.
        req0 = 1; d0 = 1;
        tick();
        idle();
        pop_req = 1;
        tick();
        check("uf_pre_dout", dout, 1);
        pop_req = 1;
        tick();
        check("uf_pulse", underflow_err, 1);
        check("uf_valid", pop_valid, 0);
        check("uf_dout_hold", dout, 1);
        idle();
        tick();
        check("uf_drop", underflow_err, 0);

        // Mid-stream reset with count 2; last_grant was left at 0.
        req0 = 1; d0 = 1;
        tick();
        tick();
        check("pre_rst_count", count, 2);
        idle();
        reset = 1; pop_req = 1;
        tick();
        check("mr_count", count, 0);
        check("mr_dout", dout, 0);
        check("mr_valid", pop_valid, 0);
        reset = 0; idle();
        req0 = 1; d0 = 1; req1 = 1; d1 = 0;
        #1;
        check("mr_grant0", grant0, 1);
        check("mr_grant1", grant1, 0);
        tick();
        check("mr_valid_after", pop_valid, 0);
        check("mr_count1", count, 1);
        idle();
        pop_req = 1;
        tick();
        check("mr_pop_dout", dout, 1);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
